matvec_engine: RTL and testbench
================================

// Module: matvec_engine
// PURPOSE
// Parametrised matrix-vector multiplier: fetches vector B and ROWS rows of matrix A from
// word-addressed memory over an Avalon-MM read master, computes C[r] = sum_k A[r][k]*B[k]
// on ROWS parallel MAC lanes, then streams the ROWS results out over a valid/ready port.
// Sits between the memory wrapper and the result consumer (LED/display logic or host readout).
// PARAMETERS
// ROWS    8   rows of A = number of MAC lanes = number of results
// COLS    8   columns of A = elements of B = elements packed per memory word
// DATA_W  8   element width
// ACC_W   24  accumulator/result width; must be >= 2*DATA_W
// ADDR_W  32  memory word-address width
// SIGNED  0   0: unsigned elements; 1: two's-complement elements and results
// PORTS
// clk               in   1              clock
// rst_n             in   1              async active-low reset
// start             in   1              pulse: begin job at base_addr (ignored unless IDLE)
// base_addr         in   ADDR_W         word address of B; A row r at base_addr+1+r
// busy              out  1              high in every state except IDLE
// done              out  1              one-cycle pulse after last result accepted
// mem_address       out  ADDR_W         Avalon read address (word)
// mem_read          out  1              Avalon read request
// mem_readdata      in   COLS*DATA_W    element k at [k*DATA_W +: DATA_W]
// mem_readdatavalid in   1              response valid, in request order
// mem_waitrequest   in   1              slave stall
// res_valid         out  1              result available
// res_ready         in   1              consumer accepts on res_valid & res_ready
// res_row           out  $clog2(ROWS)   row index of res_data
// res_data          out  ACC_W          C[res_row]
// BEHAVIOUR
// - Reset: state=IDLE; busy, done, mem_read, res_valid = 0; mem_address, res_row, res_data = 0;
//   accumulators, buffers and counters cleared. Reset mid-job aborts it; late read responses ignored.
// - FSM IDLE -> FETCH -> CALC -> OUT -> DONE -> IDLE.
// - IDLE: on start latch base_addr, clear req/resp counters, go FETCH next cycle.
// - FETCH: mem_read=1 until ROWS+1 requests accepted (mem_read & ~mem_waitrequest); address and
//   read held stable while waitrequest=1; address +1 per acceptance (pipelined, no wait for data).
//   Response n (count of readdatavalid) stored: n=0 -> B register, n>=1 -> A row n-1 buffer.
//   readdatavalid in the same cycle as a request acceptance handled independently.
//   Cycle after the (ROWS+1)th response sampled: CALC, accumulators cleared on entry.
// - CALC: COLS cycles, k=0..COLS-1; each lane r: acc_r += A[r][k]*B[k] (registered).
//   Products/sums sign- or zero-extended per SIGNED; sum wraps modulo 2^ACC_W, no saturation.
// - Latency: last response at cycle T -> CALC T+1..T+COLS -> OUT and res_valid=1 at T+COLS+1.
// - OUT: present rows 0..ROWS-1 in order; res_row/res_data stable while res_valid & ~res_ready;
//   advance one row per handshake; after row ROWS-1 accepted -> DONE (res_valid=0).
// - DONE: done=1 for exactly one cycle, then IDLE. start during any non-IDLE state is dropped.
// STRUCTURE
// - matvec_pkg: state enum (IDLE/FETCH/CALC/OUT/DONE), element-slice function, ACC_W check.
// - Sub-module matvec_mac: one lane (clk, rst_n, clr, en, a, b, SIGNED, acc); instantiated ROWS times.
// - Top holds FSM, Avalon request/response counters, A/B buffers, column index, output mux.
// TESTING (defaults unless stated)
// - B=1..8, A=identity, no stalls -> res_row 0..7 with res_data 1..8; done one pulse; 9 reads
//   at base_addr..base_addr+8.
// - All elements 8'hFF -> every res_data = 24'h07F008 (8*255*255).
// - Random waitrequest + readdatavalid gaps on test 1 -> identical results, exactly 9 accepted reads,
//   mem_address stable during stalls.
// - res_ready low 5 cycles at row 3 -> res_row=3/res_data held; rows 4..7 follow in order.
// - SIGNED=1, A all 8'hFF (-1), B all 8'h02 -> every res_data = 24'hFFFFF0 (-16).
// - rst_n asserted mid-CALC -> all outputs at reset values next cycle; fresh start gives test-1 results.

Source files
------------

// File: rtl/matvec_pkg.sv
// rtl/matvec_pkg.sv - shared state encoding and helpers for the matrix-vector engine
package matvec_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_FETCH = 3'd1;
    localparam state_t ST_CALC  = 3'd2;
    localparam state_t ST_OUT   = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    // Bit offset of element k inside a packed memory word.
    function automatic int elem_lsb(input int k, input int w);
        return k * w;
    endfunction

    // The accumulator must hold a full product without truncation.
    function automatic bit acc_w_ok(input int acc_w, input int data_w);
        return acc_w >= 2 * data_w;
    endfunction

endpackage

// File: rtl/matvec_if.sv
// rtl/matvec_if.sv - control, Avalon read master and result stream bundle
// master: engine side (drives busy/done, mem_address/mem_read, res_valid/res_row/res_data)
// slave : environment side (drives start/base_addr, mem_readdata/valid/waitrequest, res_ready)
interface matvec_if #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 32
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                     start;
    logic [ADDR_W-1:0]        base_addr;
    logic                     busy;
    logic                     done;
    logic [ADDR_W-1:0]        mem_address;
    logic                     mem_read;
    logic [COLS*DATA_W-1:0]   mem_readdata;
    logic                     mem_readdatavalid;
    logic                     mem_waitrequest;
    logic                     res_valid;
    logic                     res_ready;
    logic [RW-1:0]            res_row;
    logic [ACC_W-1:0]         res_data;

    modport master (
        input  start, base_addr, mem_readdata, mem_readdatavalid, mem_waitrequest, res_ready,
        output busy, done, mem_address, mem_read, res_valid, res_row, res_data
    );

    modport slave (
        output start, base_addr, mem_readdata, mem_readdatavalid, mem_waitrequest, res_ready,
        input  busy, done, mem_address, mem_read, res_valid, res_row, res_data
    );
endinterface

// File: rtl/matvec_mac.sv
// rtl/matvec_mac.sv - one multiply-accumulate lane
// clk, rst_n : clock, async active-low reset
// clr_i      : clear accumulator (wins over en_i)
// en_i       : accumulate a_i*b_i this cycle
// a_i, b_i   : elements, signed or unsigned per SIGNED
// acc_o      : running sum, wraps modulo 2^ACC_W
module matvec_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int SIGNED = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [ACC_W-1:0]  acc_o
);
    logic              a_fill, b_fill;
    logic [ACC_W-1:0]  a_ext, b_ext;
    logic [ACC_W-1:0]  acc_q;

    // Extending operands to ACC_W before multiplying makes the low ACC_W bits
    // of the product correct for both signed and unsigned elements.
    always_comb begin
        a_fill = (SIGNED != 0) && a_i[DATA_W-1];
        b_fill = (SIGNED != 0) && b_i[DATA_W-1];
        a_ext  = {{(ACC_W-DATA_W){a_fill}}, a_i};
        b_ext  = {{(ACC_W-DATA_W){b_fill}}, b_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + a_ext * b_ext;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matvec_engine.sv
// rtl/matvec_engine.sv - fetch B and A over Avalon, multiply on ROWS MAC lanes, stream C
// clk, rst_n : clock, async active-low reset
// bus        : matvec_if.master - start/base_addr/busy/done, Avalon read master
//              (mem_address/mem_read/mem_readdata/mem_readdatavalid/mem_waitrequest),
//              result stream (res_valid/res_ready/res_row/res_data)
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 32,
    parameter int SIGNED = 0
) (
    input  logic     clk,
    input  logic     rst_n,
    matvec_if.master bus
);
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CW  = $clog2(ROWS + 2);
    localparam int WW  = COLS * DATA_W;
    localparam logic [CW-1:0] NREQ = CW'(ROWS + 1);

    if (!acc_w_ok(ACC_W, DATA_W)) begin : g_bad_acc_w
        $error("matvec_engine: ACC_W must be >= 2*DATA_W");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CW-1:0]     req_cnt_q, req_cnt_d;
    logic [CW-1:0]     rsp_cnt_q, rsp_cnt_d;
    logic [CLW-1:0]    col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [WW-1:0]     b_q;
    logic [WW-1:0]     a_q [ROWS];
    logic [ACC_W-1:0]  acc [ROWS];
    logic [DATA_W-1:0] b_elem;
    logic [RW-1:0]     a_idx;
    logic              req_fire, rsp_fire, last_rsp, calc_en;

    assign bus.mem_read = (state_q == ST_FETCH) && (req_cnt_q < NREQ);
    assign req_fire     = bus.mem_read && !bus.mem_waitrequest;
    // Responses are only meaningful while fetching; stragglers from an aborted job are dropped.
    assign rsp_fire     = (state_q == ST_FETCH) && bus.mem_readdatavalid;
    assign last_rsp     = rsp_fire && (rsp_cnt_q == CW'(ROWS));
    assign calc_en      = (state_q == ST_CALC);
    assign a_idx        = RW'(rsp_cnt_q - CW'(1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_cnt_q;
        col_d     = col_q;
        row_d     = row_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    addr_d    = bus.base_addr;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Requests and responses are counted independently; both may fire together.
                if (req_fire) begin
                    addr_d    = addr_q + ADDR_W'(1);
                    req_cnt_d = req_cnt_q + CW'(1);
                end
                if (rsp_fire) begin
                    rsp_cnt_d = rsp_cnt_q + CW'(1);
                end
                if (last_rsp) begin
                    col_d   = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                col_d = col_q + CLW'(1);
                if (col_q == CLW'(COLS - 1)) begin
                    row_d   = '0;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.res_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            ST_DONE: begin
                row_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
            col_q     <= col_d;
            row_q     <= row_d;
        end
    end

    // First response is B, each following one is the next row of A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q <= '0;
            for (int r = 0; r < ROWS; r++) begin
                a_q[r] <= '0;
            end
        end else if (rsp_fire) begin
            if (rsp_cnt_q == '0) begin
                b_q <= bus.mem_readdata;
            end else begin
                a_q[a_idx] <= bus.mem_readdata;
            end
        end
    end

    always_comb begin
        b_elem = b_q[elem_lsb(int'(col_q), DATA_W) +: DATA_W];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        matvec_mac #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .SIGNED (SIGNED)
        ) u_mac (
            .clk   (clk),
            .rst_n (rst_n),
            .clr_i (last_rsp),
            .en_i  (calc_en),
            .a_i   (a_q[r][elem_lsb(int'(col_q), DATA_W) +: DATA_W]),
            .b_i   (b_elem),
            .acc_o (acc[r])
        );
    end

    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.mem_address = addr_q;
    assign bus.res_valid   = (state_q == ST_OUT);
    assign bus.res_row     = row_q;
    assign bus.res_data    = acc[row_q];

endmodule

// File: tb/tb_matvec_engine.sv
// tb/tb_matvec_engine.sv - self-checking bench for matvec_engine
module tb_matvec_engine;

    typedef struct {
        string       name;
        int          pat;       // 0 identity/B=1..8, 1 all 0xFF, 2 random
        bit          stall;     // random waitrequest and response gaps
        int          hold_row;  // row held 5 cycles with res_ready low, -1 none
        bit          restart;   // extra start pulse mid-job (must be dropped)
        logic [23:0] exp0;      // expected C[r] = exp0 + r*step ...
        logic [23:0] step;
        bit          use_model; // ... unless the reference model supplies it
    } job_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matvec_if bus0 ();
    matvec_if bus1 ();

    matvec_engine #(.SIGNED(0)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus0));
    matvec_engine #(.SIGNED(1)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(bus1));

    int          checks = 0;
    int          errors = 0;
    int          vec_b [8];
    int          mat_a [8][8];
    logic [63:0] mem0 [64];
    logic [63:0] mem1 [64];
    logic [5:0]  pend0 [$];
    logic [5:0]  pend1 [$];
    logic [31:0] log0 [$];
    bit          stall_en = 1'b0;
    bit          w0;
    bit          prev_stall0 = 1'b0;
    logic [31:0] prev_addr0 = '0;
    logic [23:0] exp_c [8];
    job_t        jobs [7];
    logic [31:0] base;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic job_t mk_job(input string nm, input int pat, input bit stall, input int hold,
                                    input bit restart, input logic [23:0] e0, input logic [23:0] st,
                                    input bit mdl);
        job_t j;
        j.name = nm; j.pat = pat; j.stall = stall; j.hold_row = hold; j.restart = restart;
        j.exp0 = e0; j.step = st; j.use_model = mdl;
        return j;
    endfunction

    // Reference: C[r] = sum_k A[r][k]*B[k], reduced modulo 2^24.
    function automatic logic [23:0] ref_row(input int r, input bit sgn);
        longint sum;
        longint a;
        longint b;
        sum = 0;
        for (int k = 0; k < 8; k++) begin
            a = mat_a[r][k];
            b = vec_b[k];
            if (sgn && a > 127) a -= 256;
            if (sgn && b > 127) b -= 256;
            sum += a * b;
        end
        return sum[23:0];
    endfunction

    task automatic fill_pattern(input int pat);
        for (int k = 0; k < 8; k++) begin
            vec_b[k] = (pat == 0) ? k + 1 : (pat == 1) ? 255 : int'($urandom_range(0, 255));
            for (int r = 0; r < 8; r++) begin
                mat_a[r][k] = (pat == 0) ? ((r == k) ? 1 : 0) :
                              (pat == 1) ? 255 : int'($urandom_range(0, 255));
            end
        end
    endtask

    task automatic load_mem(input bit which, input logic [31:0] b_addr);
        logic [63:0] w;
        logic [5:0]  idx;
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < 8; k++) begin
                w[k*8 +: 8] = (i == 0) ? 8'(vec_b[k]) : 8'(mat_a[i-1][k]);
            end
            idx = 6'(b_addr + 32'(i));
            if (which) mem1[idx] = w;
            else       mem0[idx] = w;
        end
    endtask

    task automatic chk_idle0(input string nm);
        check({nm, "_busy"},      bus0.busy,        1'b0);
        check({nm, "_done"},      bus0.done,        1'b0);
        check({nm, "_mem_read"},  bus0.mem_read,    1'b0);
        check({nm, "_res_valid"}, bus0.res_valid,   1'b0);
        check({nm, "_mem_addr"},  bus0.mem_address, 32'h0);
        check({nm, "_res_row"},   bus0.res_row,     3'h0);
        check({nm, "_res_data"},  bus0.res_data,    24'h0);
    endtask

    // Memory slave for both DUTs: decisions made on the falling edge for the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend0.delete();
            pend1.delete();
            bus0.mem_readdatavalid = 1'b0; bus0.mem_waitrequest = 1'b0; bus0.mem_readdata = '0;
            bus1.mem_readdatavalid = 1'b0; bus1.mem_waitrequest = 1'b0; bus1.mem_readdata = '0;
            prev_stall0 = 1'b0;
        end else begin
            if (prev_stall0) begin
                checks++;
                if (bus0.mem_read !== 1'b1 || bus0.mem_address !== prev_addr0) begin
                    errors++;
                    $display("FAIL addr_stable got read=%0b addr=%0h exp read=1 addr=%0h",
                             bus0.mem_read, bus0.mem_address, prev_addr0);
                end
            end
            if (pend0.size() > 0 && !(stall_en && $urandom_range(0, 2) == 0)) begin
                bus0.mem_readdatavalid = 1'b1;
                bus0.mem_readdata      = mem0[pend0.pop_front()];
            end else begin
                bus0.mem_readdatavalid = 1'b0;
                bus0.mem_readdata      = '0;
            end
            w0 = stall_en && ($urandom_range(0, 1) == 1);
            bus0.mem_waitrequest = w0;
            if (bus0.mem_read && !w0) begin
                pend0.push_back(bus0.mem_address[5:0]);
                log0.push_back(bus0.mem_address);
            end
            prev_stall0 = bus0.mem_read && w0;
            prev_addr0  = bus0.mem_address;

            if (pend1.size() > 0) begin
                bus1.mem_readdatavalid = 1'b1;
                bus1.mem_readdata      = mem1[pend1.pop_front()];
            end else begin
                bus1.mem_readdatavalid = 1'b0;
                bus1.mem_readdata      = '0;
            end
            bus1.mem_waitrequest = 1'b0;
            if (bus1.mem_read) pend1.push_back(bus1.mem_address[5:0]);
        end
    end

    task automatic run_job0(input string nm, input logic [31:0] b_addr, input bit stall,
                            input int hold_row, input bit restart);
        int row;
        int cyc;
        int held;
        bit ok;
        stall_en = stall;
        log0.delete();
        @(negedge clk); bus0.base_addr = b_addr; bus0.start = 1'b1;
        @(negedge clk); bus0.start = 1'b0;
        check({nm, "_busy"}, bus0.busy, 1'b1);
        row = 0; cyc = 0; held = 0;
        while (row < 8 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            bus0.start     = restart && (cyc == 3);
            bus0.res_ready = 1'b1;
            if (bus0.res_valid) begin
                check({nm, "_row"},  bus0.res_row,  row);
                check({nm, "_data"}, bus0.res_data, exp_c[row]);
                if (row == hold_row && held < 5) begin
                    bus0.res_ready = 1'b0;
                    held++;
                end
                if (bus0.res_ready) row++;
            end
        end
        bus0.start = 1'b0;
        check({nm, "_timeout_rows"}, row, 8);
        check({nm, "_held"}, held, (hold_row >= 0) ? 5 : 0);
        @(negedge clk); bus0.res_ready = 1'b0;
        check({nm, "_done_pulse"}, bus0.done, 1'b1);
        check({nm, "_out_valid_off"}, bus0.res_valid, 1'b0);
        @(negedge clk);
        check({nm, "_done_clear"}, bus0.done, 1'b0);
        check({nm, "_idle"}, bus0.busy, 1'b0);
        check({nm, "_nreads"}, log0.size(), 9);
        ok = 1'b1;
        for (int i = 0; i < log0.size(); i++) begin
            if (log0[i] !== b_addr + 32'(i)) ok = 1'b0;
        end
        check({nm, "_read_addrs"}, ok, 1'b1);
    endtask

    task automatic run_job1(input string nm, input logic [31:0] b_addr);
        int row;
        int cyc;
        @(negedge clk); bus1.base_addr = b_addr; bus1.start = 1'b1;
        @(negedge clk); bus1.start = 1'b0;
        row = 0; cyc = 0;
        bus1.res_ready = 1'b1;
        while (row < 8 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (bus1.res_valid) begin
                check({nm, "_row"},  bus1.res_row,  row);
                check({nm, "_data"}, bus1.res_data, exp_c[row]);
                row++;
            end
        end
        check({nm, "_timeout_rows"}, row, 8);
        @(negedge clk); bus1.res_ready = 1'b0;
        check({nm, "_done_pulse"}, bus1.done, 1'b1);
        @(negedge clk);
        check({nm, "_idle"}, bus1.busy, 1'b0);
    endtask

    initial begin
        jobs[0] = mk_job("ident",       0, 1'b0, -1, 1'b0, 24'd1,       24'd1, 1'b0);
        jobs[1] = mk_job("all_ff",      1, 1'b0, -1, 1'b0, 24'h07F008,  24'd0, 1'b0);
        jobs[2] = mk_job("ident_stall", 0, 1'b1, -1, 1'b0, 24'd1,       24'd1, 1'b0);
        jobs[3] = mk_job("ident_hold3", 0, 1'b0,  3, 1'b0, 24'd1,       24'd1, 1'b0);
        jobs[4] = mk_job("rand_restart",2, 1'b1, -1, 1'b1, 24'd0,       24'd0, 1'b1);
        jobs[5] = mk_job("rand_hold5",  2, 1'b0,  5, 1'b0, 24'd0,       24'd0, 1'b1);
        jobs[6] = mk_job("rand_stall",  2, 1'b1, -1, 1'b0, 24'd0,       24'd0, 1'b1);

        bus0.start = 1'b0; bus0.base_addr = '0; bus0.res_ready = 1'b0;
        bus1.start = 1'b0; bus1.base_addr = '0; bus1.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle0("reset");
        check("reset_s_busy",      bus1.busy,      1'b0);
        check("reset_s_res_valid", bus1.res_valid, 1'b0);
        check("reset_s_res_data",  bus1.res_data,  24'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int j = 0; j < 7; j++) begin
            fill_pattern(jobs[j].pat);
            base = $urandom();
            load_mem(1'b0, base);
            for (int r = 0; r < 8; r++) begin
                exp_c[r] = jobs[j].use_model ? ref_row(r, 1'b0)
                                             : jobs[j].exp0 + 24'(r) * jobs[j].step;
            end
            run_job0(jobs[j].name, base, jobs[j].stall, jobs[j].hold_row, jobs[j].restart);
        end

        // Abort a job in the middle of CALC, then rerun it from scratch.
        fill_pattern(0);
        base = 32'h0000_1230;
        load_mem(1'b0, base);
        for (int r = 0; r < 8; r++) exp_c[r] = 24'(r + 1);
        stall_en = 1'b0;
        @(negedge clk); bus0.base_addr = base; bus0.start = 1'b1;
        @(negedge clk); bus0.start = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_busy",     bus0.busy,      1'b1);
        check("mid_no_read",  bus0.mem_read,  1'b0);
        check("mid_no_valid", bus0.res_valid, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle0("rst_mid");
        rst_n = 1'b1;
        @(negedge clk);
        run_job0("after_rst", base, 1'b0, -1, 1'b0);

        // Signed lane: A = -1, B = 2 gives -16 per row; then a random signed job.
        for (int k = 0; k < 8; k++) begin
            vec_b[k] = 2;
            for (int r = 0; r < 8; r++) mat_a[r][k] = 255;
        end
        base = 32'h0000_0040;
        load_mem(1'b1, base);
        for (int r = 0; r < 8; r++) exp_c[r] = 24'hFFFFF0;
        run_job1("signed_neg", base);

        fill_pattern(2);
        base = $urandom();
        load_mem(1'b1, base);
        for (int r = 0; r < 8; r++) exp_c[r] = ref_row(r, 1'b1);
        run_job1("signed_rand", base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
